// File: rtl/bus_master_if.sv
// Per-master bus interface: turns one core access into the req/grant/strobe/ready
// bus sequence, holding req_ low for the whole transaction, with optional timeout abort.
module bus_master_if #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_rw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_busy,
    output logic              core_done,
    output logic              core_err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACCESS,
        WAIT
    } state_t;

    localparam bit            TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            bus_req_     <= 1'b1;
            bus_as_      <= 1'b1;
            bus_rw       <= 1'b1;
            bus_addr     <= '0;
            bus_wr_data  <= '0;
            core_rd_data <= '0;
            core_busy    <= 1'b0;
            core_done    <= 1'b0;
            core_err     <= 1'b0;
        end else begin
            core_done <= 1'b0;
            core_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req) begin
                        bus_rw      <= core_rw;
                        bus_addr    <= core_addr;
                        bus_wr_data <= core_wr_data;
                        bus_req_    <= 1'b0;
                        core_busy   <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    // No timeout here: waiting on the arbiter is not a slave fault.
                    if (!bus_grnt_) begin
                        bus_as_ <= 1'b0;
                        count   <= '0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus_as_ <= 1'b1;
                    if (!bus_rdy_) begin
                        if (bus_rw) core_rd_data <= bus_rd_data;
                        core_done <= 1'b1;
                        bus_req_  <= 1'b1;
                        core_busy <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // Ready on the expiry edge takes priority over the abort.
                    if (!bus_rdy_) begin
                        if (bus_rw) core_rd_data <= bus_rd_data;
                        core_done <= 1'b1;
                        bus_req_  <= 1'b1;
                        core_busy <= 1'b0;
                        state     <= IDLE;
                    end else if (TO_EN && count == TO_LAST) begin
                        core_done <= 1'b1;
                        core_err  <= 1'b1;
                        bus_req_  <= 1'b1;
                        core_busy <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_if.sv
// Randomized scoreboard bench for bus_master_if: a driver plays core and slave,
// pushing expected completions; a monitor pops and checks on every core_done pulse.
module tb_bus_master_if;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          core_req = 1'b0;
    logic          core_rw = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wr_data = '0;
    logic [DW-1:0] core_rd_data;
    logic          core_busy, core_done, core_err;
    logic          bus_req_;
    logic          bus_grnt_ = 1'b1;
    logic [AW-1:0] bus_addr;
    logic          bus_as_, bus_rw;
    logic [DW-1:0] bus_wr_data;
    logic [DW-1:0] bus_rd_data = '0;
    logic          bus_rdy_ = 1'b1;

    bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TO_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_rw(core_rw), .core_addr(core_addr),
        .core_wr_data(core_wr_data), .core_rd_data(core_rd_data),
        .core_busy(core_busy), .core_done(core_done), .core_err(core_err),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
        .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          rw;
        logic          err;
        logic [DW-1:0] rd_data;
        int            done_cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] exp_rd = '0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (core_done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                check("err", 64'(core_err), 64'(e.err));
                check("rd_data", 64'(core_rd_data), 64'(e.rd_data));
                check("req_released", 64'(bus_req_), 64'd1);
                check("busy_cleared", 64'(core_busy), 64'd0);
            end
        end
    end

    // One core access; g = grant delay cycles, d = ready index after strobe (d >= TO: never in time).
    task automatic run_txn(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rd, input int g, input int d);
        exp_t e;
        int   lat;
        logic done;
        lat = (d < TO - 1) ? d : TO - 1;
        e.rw       = rw;
        e.err      = (d >= TO);
        e.done_cyc = cyc + 3 + g + lat;
        if (rw && !e.err) exp_rd = rd;
        e.rd_data  = exp_rd;
        sb.push_back(e);

        core_req = 1'b1; core_rw = rw; core_addr = addr; core_wr_data = wd;
        @(negedge clk);
        core_req = 1'b0;
        check("busy_after_accept", 64'(core_busy), 64'd1);
        check("req_low", 64'(bus_req_), 64'd0);
        for (int i = 0; i < g; i++) begin
            check("as_before_grant", 64'(bus_as_), 64'd1);
            @(negedge clk);
            check("req_held_grant", 64'(bus_req_), 64'd0);
        end
        bus_grnt_ = 1'b0;
        @(negedge clk);
        bus_grnt_ = 1'b1;
        check("as_low", 64'(bus_as_), 64'd0);
        check("bus_addr", 64'(bus_addr), 64'(addr));
        check("bus_rw", 64'(bus_rw), 64'(rw));
        if (!rw) check("bus_wr_data", 64'(bus_wr_data), 64'(wd));

        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            bus_rdy_    = (i == d) ? 1'b0 : 1'b1;
            bus_rd_data = (i == d) ? rd : $urandom;
            @(negedge clk);
            if (core_done) done = 1'b1;
            else begin
                check("as_one_cycle", 64'(bus_as_), 64'd1);
                check("req_held_wait", 64'(bus_req_), 64'd0);
            end
        end
        bus_rdy_ = 1'b1;
        check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic check_reset_values();
        check("rst_req", 64'(bus_req_), 64'd1);
        check("rst_as", 64'(bus_as_), 64'd1);
        check("rst_rw", 64'(bus_rw), 64'd1);
        check("rst_addr", 64'(bus_addr), 64'd0);
        check("rst_wr_data", 64'(bus_wr_data), 64'd0);
        check("rst_rd_data", 64'(core_rd_data), 64'd0);
        check("rst_busy", 64'(core_busy), 64'd0);
        check("rst_done", 64'(core_done), 64'd0);
        check("rst_err", 64'(core_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        run_txn(1'b1, 30'h100, '0, 32'hDEADBEEF, 0, 0);
        repeat (2) @(negedge clk);
        run_txn(1'b0, 30'h200, 32'h12345678, 32'hCAFEF00D, 5, 0);
        @(negedge clk);
        run_txn(1'b1, 30'h300, '0, 32'hA5A5A5A5, 0, 4);
        @(negedge clk);
        run_txn(1'b1, 30'h400, '0, 32'h11111111, 1, 100);
        @(negedge clk);
        run_txn(1'b1, 30'h500, '0, 32'h77777777, 0, TO - 1);
        @(negedge clk);
        run_txn(1'b1, 30'h600, '0, 32'h01020304, 0, 0);
        run_txn(1'b1, 30'h604, '0, 32'h05060708, 2, 1);

        // Reset two cycles into WAIT
        core_req = 1'b1; core_rw = 1'b1; core_addr = 30'h700;
        @(negedge clk);
        core_req = 1'b0;
        bus_grnt_ = 1'b0;
        @(negedge clk);
        bus_grnt_ = 1'b1;
        bus_rdy_ = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        exp_rd = '0;
        reset = 1'b0;
        @(negedge clk);
        check("no_pulse_after_reset", 64'(core_done), 64'd0);
        run_txn(1'b1, 30'h800, '0, 32'hBEEF0001, 0, 2);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 10)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
